// File: rtl/display7_pkg.sv
// Shared constants and width helper for the multiplexed 7-segment display driver.
// Segment patterns are active-high here; polarity is applied at the output registers.
package display7_pkg;

  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // Width of the digit index; a single-digit bank still needs one bit.
  function automatic int idx_w(input int digits);
    return (digits <= 1) ? 1 : $clog2(digits);
  endfunction

endpackage

// File: rtl/display7_scan_decode.sv
// Nibble to 7-segment pattern (bit0=a .. bit6=g), active-high, purely combinational.
// In decimal mode, nibbles A-F collapse to a dash so invalid BCD is visible.
module seg7_decode
  import display7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       mode,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = SEG_OFF;
    endcase
    if (mode && (nibble > 4'd9)) begin
      seg = SEG_DASH;
    end
  end

endmodule

// File: rtl/display7_scan.sv
// Time-multiplexed common-anode 7-segment driver with frame-synchronous loading.
// All outputs are registered one cycle behind the prescaler/index/display state.
module display7_scan
  import display7_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int CLK_DIV        = 100000,
  parameter int GHOST          = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic [4*DIGITS-1:0]   iData,
  input  logic [DIGITS-1:0]     iDp,
  input  logic [DIGITS-1:0]     iBlank,
  input  logic                  iMode,
  input  logic                  iLoad,
  output logic [6:0]            oSeg,
  output logic                  oDp,
  output logic [DIGITS-1:0]     oAn,
  output logic                  oFrame
);

  localparam int IDX_W = idx_w(DIGITS);
  localparam int PW    = $clog2(CLK_DIV);

  localparam logic [PW-1:0]    PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  localparam logic [6:0]        SEG_DARK = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic              DP_DARK  = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] AN_DARK  = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [PW-1:0]         presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;

  logic [4*DIGITS-1:0]   pend_data_q, pend_data_d;
  logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
  logic [DIGITS-1:0]     pend_blank_q, pend_blank_d;
  logic                  pend_mode_q, pend_mode_d;
  logic                  pend_vld_q, pend_vld_d;

  logic [4*DIGITS-1:0]   disp_data_q, disp_data_d;
  logic [DIGITS-1:0]     disp_dp_q, disp_dp_d;
  logic [DIGITS-1:0]     disp_blank_q, disp_blank_d;
  logic                  disp_mode_q, disp_mode_d;

  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic                  frame_q, frame_d;

  logic                  tick;
  logic                  frame_end;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;
  logic [6:0]            dec_seg;
  logic [6:0]            seg_raw;
  logic                  an_en;
  logic [DIGITS-1:0]     an_raw;

  assign tick      = (presc_q == PRESC_LAST);
  assign frame_end = tick && (idx_q == IDX_LAST);

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    idx_d   = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Display only ever changes at a frame boundary and always takes the pending
  // contents as they stood before this cycle, so a coincident load waits a frame.
  always_comb begin
    disp_data_d  = disp_data_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    disp_mode_d  = disp_mode_q;
    if (frame_end && pend_vld_q) begin
      disp_data_d  = pend_data_q;
      disp_dp_d    = pend_dp_q;
      disp_blank_d = pend_blank_q;
      disp_mode_d  = pend_mode_q;
    end

    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pend_mode_d  = pend_mode_q;
    pend_vld_d   = pend_vld_q;
    if (iLoad) begin
      pend_data_d  = iData;
      pend_dp_d    = iDp;
      pend_blank_d = iBlank;
      pend_mode_d  = iMode;
      pend_vld_d   = 1'b1;
    end else if (frame_end) begin
      pend_vld_d   = 1'b0;
    end
  end

  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_nib   = disp_data_q[4*k +: 4];
        cur_dp    = disp_dp_q[k];
        cur_blank = disp_blank_q[k];
      end
    end
  end

  seg7_decode u_decode (
    .nibble (cur_nib),
    .mode   (disp_mode_q),
    .seg    (dec_seg)
  );

  // The first GHOST cycles of each slot keep every anode dark while segments settle.
  always_comb begin
    an_en   = (int'(presc_q) >= GHOST);
    an_raw  = '0;
    for (int k = 0; k < DIGITS; k++) begin
      an_raw[k] = an_en && (idx_q == IDX_W'(k));
    end
    seg_raw = cur_blank ? SEG_OFF : dec_seg;

    seg_d   = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
    dp_d    = (SEG_ACTIVE_LOW != 0) ? ~(cur_dp & ~cur_blank) : (cur_dp & ~cur_blank);
    an_d    = (AN_ACTIVE_LOW != 0) ? ~an_raw : an_raw;
    frame_d = frame_end;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      pend_mode_q  <= 1'b0;
      pend_vld_q   <= 1'b0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '0;
      disp_mode_q  <= 1'b0;
      seg_q        <= SEG_DARK;
      dp_q         <= DP_DARK;
      an_q         <= AN_DARK;
      frame_q      <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pend_mode_q  <= pend_mode_d;
      pend_vld_q   <= pend_vld_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      disp_mode_q  <= disp_mode_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_q      <= frame_d;
    end
  end

  assign oSeg   = seg_q;
  assign oDp    = dp_q;
  assign oAn    = an_q;
  assign oFrame = frame_q;

endmodule

// File: tb/tb_display7_scan.sv
// Bench for display7_scan: 4 digits, 4-cycle slots, 1 ghost cycle, active-low pins.
module tb_display7_scan;

  localparam int D  = 4;
  localparam int CD = 4;
  localparam int G  = 1;
  localparam int FR = D * CD;

  logic        iClk;
  logic        iRst;
  logic [15:0] iData;
  logic [3:0]  iDp;
  logic [3:0]  iBlank;
  logic        iMode;
  logic        iLoad;
  logic [6:0]  oSeg;
  logic        oDp;
  logic [3:0]  oAn;
  logic        oFrame;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  display7_scan #(
    .DIGITS(D), .CLK_DIV(CD), .GHOST(G), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iData(iData), .iDp(iDp), .iBlank(iBlank),
    .iMode(iMode), .iLoad(iLoad), .oSeg(oSeg), .oDp(oDp), .oAn(oAn), .oFrame(oFrame)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: time since reset determines slot and digit; pending/display follow the load rules.
  int          m_cnt = 0;
  logic [15:0] m_pend_data, m_disp_data;
  logic [3:0]  m_pend_dp, m_pend_blank, m_disp_dp, m_disp_blank;
  logic        m_pend_mode, m_pend_vld, m_disp_mode;
  logic [12:0] exp_out;

  function automatic logic [6:0] hexseg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic logic frame_end_at(input int cnt);
    return (cnt % FR) == FR - 1;
  endfunction

  function automatic logic [12:0] f_out(input int cnt, input logic [15:0] data,
                                        input logic [3:0] dp, input logic [3:0] blank,
                                        input logic mode);
    int presc, idx;
    logic [3:0] nib, an;
    logic [6:0] seg;
    logic dpl;
    presc = cnt % CD;
    idx   = (cnt / CD) % D;
    nib   = data[idx*4 +: 4];
    if (blank[idx]) seg = 7'h00;
    else if (mode && nib > 4'd9) seg = 7'h40;
    else seg = hexseg(nib);
    an  = (presc >= G) ? 4'(1 << idx) : 4'h0;
    dpl = dp[idx] & ~blank[idx];
    return {frame_end_at(cnt), ~dpl, ~an, ~seg};
  endfunction

  always @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      m_cnt <= 0;
      m_pend_data <= '0; m_pend_dp <= '0; m_pend_blank <= '0; m_pend_mode <= 1'b0;
      m_pend_vld <= 1'b0;
      m_disp_data <= '0; m_disp_dp <= '0; m_disp_blank <= '0; m_disp_mode <= 1'b0;
      exp_out <= {1'b0, 1'b1, 4'hF, 7'h7F};
    end else begin
      exp_out <= f_out(m_cnt, m_disp_data, m_disp_dp, m_disp_blank, m_disp_mode);
      if (frame_end_at(m_cnt) && m_pend_vld) begin
        m_disp_data <= m_pend_data; m_disp_dp <= m_pend_dp;
        m_disp_blank <= m_pend_blank; m_disp_mode <= m_pend_mode;
      end
      if (iLoad) begin
        m_pend_data <= iData; m_pend_dp <= iDp; m_pend_blank <= iBlank;
        m_pend_mode <= iMode; m_pend_vld <= 1'b1;
      end else if (frame_end_at(m_cnt)) begin
        m_pend_vld <= 1'b0;
      end
      m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge iClk) begin
    if (chk_en) chk("cycle", {3'b0, oFrame, oDp, oAn, oSeg}, {3'b0, exp_out});
  end

  task automatic wait_phase(input int p);
    int n = 0;
    while ((m_cnt % FR) != p && n < 64) begin
      @(negedge iClk);
      n++;
    end
    chk("phase_wait", 16'(m_cnt % FR), 16'(p));
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge iClk);
      n++;
    end while (oFrame !== 1'b1 && n < 64);
    chk("frame_wait", {15'b0, oFrame}, 16'd1);
  endtask

  task automatic check_digit(input int k, input logic [6:0] seg_e, input logic dp_e,
                             input string nm);
    int n = 0;
    logic [3:0] want;
    want = ~(4'b0001 << k);
    while (oAn !== want && n < 40) begin
      @(negedge iClk);
      n++;
    end
    chk({nm, "_an"}, {12'b0, oAn}, {12'b0, want});
    chk({nm, "_seg"}, {9'b0, oSeg}, {9'b0, seg_e});
    chk({nm, "_dp"}, {15'b0, oDp}, {15'b0, dp_e});
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl,
                      input logic md);
    iData = d; iDp = dp; iBlank = bl; iMode = md; iLoad = 1'b1;
    @(negedge iClk);
    iLoad = 1'b0;
  endtask

  initial begin
    logic [3:0] an_e;
    iRst = 1'b0; iData = '0; iDp = '0; iBlank = '0; iMode = 1'b0; iLoad = 1'b0;
    #1 iRst = 1'b1;
    #1 chk_en = 1'b1;
    repeat (3) @(negedge iClk);
    chk("reset_out", {3'b0, oFrame, oDp, oAn, oSeg}, {3'b0, 1'b0, 1'b1, 4'hF, 7'h7F});
    iRst = 1'b0;

    // First frame after release: one dark cycle per slot, digits 0..3 in turn.
    for (int j = 0; j < FR; j++) begin
      @(negedge iClk);
      an_e = ((j % CD) == 0) ? 4'hF : ~(4'b0001 << (j / CD));
      chk("scan_an", {12'b0, oAn}, {12'b0, an_e});
      chk("scan_frame", {15'b0, oFrame}, {15'b0, (j == FR - 1)});
    end

    wait_phase(5);
    load(16'hA3F0, 4'b0000, 4'b0000, 1'b0);
    wait_frame();
    check_digit(0, 7'h40, 1'b1, "hex_d0");
    check_digit(1, 7'h0E, 1'b1, "hex_d1");
    check_digit(2, 7'h30, 1'b1, "hex_d2");
    check_digit(3, 7'h08, 1'b1, "hex_d3");

    wait_phase(5);
    load(16'hA3F0, 4'b0000, 4'b0000, 1'b1);
    wait_frame();
    check_digit(0, 7'h40, 1'b1, "dec_d0");
    check_digit(1, 7'h3F, 1'b1, "dec_d1");
    check_digit(2, 7'h30, 1'b1, "dec_d2");
    check_digit(3, 7'h3F, 1'b1, "dec_d3");

    wait_phase(5);
    load(16'hA3F0, 4'b0001, 4'b0100, 1'b0);
    wait_frame();
    check_digit(0, 7'h40, 1'b0, "bdp_d0");
    check_digit(2, 7'h7F, 1'b1, "bdp_d2");

    // Load on the frame-end cycle, then overwrite mid-frame.
    wait_phase(FR - 1);
    load(16'h1111, 4'b0000, 4'b0000, 1'b0);
    wait_phase(6);
    load(16'h2222, 4'b0000, 4'b0000, 1'b0);
    check_digit(2, 7'h7F, 1'b1, "tear_old_d2");
    check_digit(3, 7'h08, 1'b1, "tear_old_d3");
    wait_frame();
    for (int k = 0; k < D; k++) check_digit(k, 7'h24, 1'b1, "tear_new");

    wait_phase(9);
    #1 iRst = 1'b1;
    #1 chk("midrst_out", {3'b0, oFrame, oDp, oAn, oSeg}, {3'b0, 1'b0, 1'b1, 4'hF, 7'h7F});
    repeat (2) @(negedge iClk);
    iRst = 1'b0;
    @(negedge iClk);
    chk("midrst_ghost", {12'b0, oAn}, 16'h000F);
    @(negedge iClk);
    chk("midrst_d0", {12'b0, oAn}, 16'h000E);
    wait_frame();
    for (int k = 0; k < D; k++) check_digit(k, 7'h40, 1'b1, "midrst_zero");

    for (int c = 0; c < 1500; c++) begin
      iData  = 16'($urandom);
      iDp    = 4'($urandom);
      iBlank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      iMode  = 1'($urandom);
      iLoad  = ($urandom_range(0, 9) == 0);
      @(negedge iClk);
    end
    iLoad = 1'b0;
    repeat (2 * FR) @(negedge iClk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
